iq_density_accum: RTL and testbench
===================================

IQ_DENSITY_ACCUM -- requirements
Module: iq_density_accum

Interface
REQ-001 Parameter IN_W, default 4: width of each signed I/Q input sample.
REQ-002 Parameter RANGE_X_MIN, default 4: lowest offset-binary I index that is counted, inclusive.
REQ-003 Parameter RANGE_X_MAX, default 12: highest offset-binary I index that is counted, inclusive.
REQ-004 Parameter RANGE_Y_MIN, default 4: lowest offset-binary Q index that is counted, inclusive.
REQ-005 Parameter RANGE_Y_MAX, default 12: highest offset-binary Q index that is counted, inclusive.
REQ-006 Parameter CNT_W, default 8: width of each cell counter.
REQ-007 Parameter FRAME_LEN, default 256: number of valid samples per accumulation frame, at least 2.
REQ-008 Derived values: GX = RANGE_X_MAX-RANGE_X_MIN+1; GY = RANGE_Y_MAX-RANGE_Y_MIN+1.
REQ-009 Port clk, input, 1: single clock; every register is rising-edge.
REQ-010 Port rst, input, 1: reset; synchronous, active-high.
REQ-011 Port in_valid, input, 1: in_i and in_q carry a sample this cycle.
REQ-012 Port in_i, input, IN_W, signed: I sample.
REQ-013 Port in_q, input, IN_W, signed: Q sample.
REQ-014 Port clear, input, 1: abort the current frame.
REQ-015 Port matrix_out, output, GY*GX*CNT_W: snapshot of the last completed frame; cell (y,x) occupies bits [(y*GX+x)*CNT_W +: CNT_W].
REQ-016 Port out_valid, output, 1: one-cycle pulse when matrix_out updates.
REQ-017 Port drop_cnt, output, 16: count of out-of-range samples in the last completed frame.

Function
REQ-018 Index mapping: idx = sample + 2^(IN_W-1), unsigned, range 0..2^IN_W-1.
REQ-019 Range check: a sample is in range only when RANGE_X_MIN<=idx_i<=RANGE_X_MAX and RANGE_Y_MIN<=idx_q<=RANGE_Y_MAX.
REQ-020 Cell selection: an in-range sample uses x = idx_i-RANGE_X_MIN and y = idx_q-RANGE_Y_MIN.
REQ-021 Pipeline stage 1: registers the valid flag, the in-range flag and (y,x) one edge after in_valid is sampled.
REQ-022 Pipeline stage 2: increments cell (y,x) on the following edge, 2 edges after input in total.
REQ-023 Counter saturation: a cell counter saturates at 2^CNT_W-1 and never wraps.
REQ-024 Out-of-range handling: an out-of-range valid sample changes no cell, increments the internal drop counter (saturating at 65535), and counts toward FRAME_LEN.
REQ-025 Sample counting: a frame counter counts stage-2 valid samples, 0..FRAME_LEN-1.
REQ-026 Frame close: on the edge that processes the FRAME_LEN-th sample, matrix_out loads the cell array including that sample's increment, drop_cnt loads the drop count including that sample, and out_valid rises for exactly one cycle.
REQ-027 Frame restart: on that same edge all cells, the drop counter and the frame counter clear to 0, and the next stage-2 sample starts the new frame with no cycle lost.
REQ-028 Back-to-back input: one sample per cycle with in_valid held high is sustained indefinitely with no stall.
REQ-029 Input gaps: in_valid low inserts bubbles that change no state.
REQ-030 Clear: clear clears cells, drop counter, frame counter and both pipeline stages on the next edge; matrix_out, drop_cnt and out_valid are unaffected except that out_valid is 0.
REQ-031 Simultaneous events: clear has priority over in_valid and over a frame close in the same cycle; the sample is discarded and no snapshot occurs.

Reset
REQ-032 rst has priority over all inputs and, on its edge, zeroes every cell, counter, pipeline stage, matrix_out, drop_cnt and out_valid.
REQ-033 Reset mid-frame discards the partial frame.
REQ-034 The first frame after reset deasserts is FRAME_LEN samples long.

Configuration
REQ-035 Macro IQ_DENSITY_DROP_CNT_EN defined: the drop counter and drop_cnt behave per REQ-017, REQ-024 and REQ-026.
REQ-036 Macro IQ_DENSITY_DROP_CNT_EN undefined: no drop counter logic exists, drop_cnt is constant 0, and out-of-range samples are still dropped and still count toward FRAME_LEN.

Verification
REQ-037 Defaults, FRAME_LEN=4, samples (I,Q) = (0,0) x4 back-to-back -> cell (4,4)=4, all other cells 0, out_valid single pulse 2 edges after the 4th sample.
REQ-038 Defaults, FRAME_LEN=4, samples (-8,0),(7,7),(0,0),(1,-1) -> cells (4,4)=1 and (3,5)=1, drop_cnt=2 (=0 without macro).
REQ-039 CNT_W=2, FRAME_LEN=8, 8 samples of (0,0) -> cell (4,4)=3, saturated, no wrap.
REQ-040 Two frames back-to-back with in_valid always high -> two out_valid pulses exactly FRAME_LEN cycles apart; second snapshot contains no first-frame counts.
REQ-041 clear asserted in the same cycle as the 4th valid sample -> no out_valid; the next 4 samples produce a snapshot with only those 4 samples; matrix_out holds its previous value throughout.
REQ-042 rst pulsed after 3 of 4 samples, then 4 new samples -> matrix_out 0 during reset, snapshot reflects only the 4 new samples.

Source files
------------

// File: rtl/iq_density_accum.sv
// 2-D I/Q constellation density histogram, closed into a snapshot every FRAME_LEN samples.
// Define IQ_DENSITY_DROP_CNT_EN to build the out-of-range drop counter behind drop_cnt.
module iq_density_accum #(
  parameter int IN_W        = 4,
  parameter int RANGE_X_MIN = 4,
  parameter int RANGE_X_MAX = 12,
  parameter int RANGE_Y_MIN = 4,
  parameter int RANGE_Y_MAX = 12,
  parameter int CNT_W       = 8,
  parameter int FRAME_LEN   = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [IN_W-1:0] in_i,
  input  logic signed [IN_W-1:0] in_q,
  input  logic                 clear,
  output logic [(RANGE_Y_MAX-RANGE_Y_MIN+1)*(RANGE_X_MAX-RANGE_X_MIN+1)*CNT_W-1:0] matrix_out,
  output logic                 out_valid,
  output logic [15:0]          drop_cnt
);
  localparam int GX    = RANGE_X_MAX - RANGE_X_MIN + 1;
  localparam int GY    = RANGE_Y_MAX - RANGE_Y_MIN + 1;
  localparam int NCELL = GX * GY;
  localparam int MW    = NCELL * CNT_W;
  localparam int FW    = $clog2(FRAME_LEN);

  localparam logic [IN_W-1:0]  X_MIN      = IN_W'(RANGE_X_MIN);
  localparam logic [IN_W-1:0]  X_MAX      = IN_W'(RANGE_X_MAX);
  localparam logic [IN_W-1:0]  Y_MIN      = IN_W'(RANGE_Y_MIN);
  localparam logic [IN_W-1:0]  Y_MAX      = IN_W'(RANGE_Y_MAX);
  localparam logic [FW-1:0]    FRAME_LAST = FW'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // Offset-binary index: adding 2^(IN_W-1) to a two's-complement value flips its MSB.
  logic [IN_W-1:0] idx_i, idx_q;
  logic            in_range;
  assign idx_i    = {~in_i[IN_W-1], in_i[IN_W-2:0]};
  assign idx_q    = {~in_q[IN_W-1], in_q[IN_W-2:0]};
  assign in_range = (idx_i >= X_MIN) && (idx_i <= X_MAX) &&
                    (idx_q >= Y_MIN) && (idx_q <= Y_MAX);

  logic            s1_valid, s1_inr;
  logic [IN_W-1:0] s1_x, s1_y;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      s1_valid <= 1'b0;
      s1_inr   <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_inr   <= in_range;
      s1_x     <= idx_i - X_MIN;
      s1_y     <= idx_q - Y_MIN;
    end
  end

  logic [MW-1:0] cells, cells_next;
  logic [FW-1:0] frame_cnt;
  logic          frame_done;
  int            sel;

  always_comb begin
    sel        = int'(s1_y) * GX + int'(s1_x);
    cells_next = cells;
    for (int c = 0; c < NCELL; c++) begin
      if (s1_valid && s1_inr && (sel == c) && (cells[c*CNT_W +: CNT_W] != CNT_MAX))
        cells_next[c*CNT_W +: CNT_W] = cells[c*CNT_W +: CNT_W] + CNT_ONE;
    end
  end

  assign frame_done = s1_valid && (frame_cnt == FRAME_LAST);

  // clear outranks a frame close landing on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cells      <= '0;
      frame_cnt  <= '0;
      matrix_out <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (clear) begin
        cells     <= '0;
        frame_cnt <= '0;
      end else if (frame_done) begin
        matrix_out <= cells_next;
        out_valid  <= 1'b1;
        cells      <= '0;
        frame_cnt  <= '0;
      end else begin
        cells <= cells_next;
        if (s1_valid)
          frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

`ifdef IQ_DENSITY_DROP_CNT_EN
  logic [15:0] drop_acc, drop_next;

  always_comb begin
    drop_next = drop_acc;
    if (s1_valid && !s1_inr && (drop_acc != 16'hFFFF))
      drop_next = drop_acc + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_acc <= '0;
      drop_cnt <= '0;
    end else if (clear) begin
      drop_acc <= '0;
    end else if (frame_done) begin
      drop_cnt <= drop_next;
      drop_acc <= '0;
    end else begin
      drop_acc <= drop_next;
    end
  end
`else
  assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_iq_density_accum.sv
// Bench for iq_density_accum: two instances (FRAME_LEN=4/CNT_W=8 and FRAME_LEN=8/CNT_W=2)
// share stimulus; a frame-level histogram model feeds per-instance expected queues.
module tb_iq_density_accum;
  localparam int W = 81 * 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, clear = 1'b0, in_valid = 1'b0;
  logic signed [3:0] in_i = '0, in_q = '0;
  logic [81*8-1:0] mat0;
  logic [81*2-1:0] mat1;
  logic            ov0, ov1;
  logic [15:0]     drop0, drop1;

  iq_density_accum #(.FRAME_LEN(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_i(in_i), .in_q(in_q), .clear(clear),
    .matrix_out(mat0), .out_valid(ov0), .drop_cnt(drop0));

  iq_density_accum #(.CNT_W(2), .FRAME_LEN(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_i(in_i), .in_q(in_q), .clear(clear),
    .matrix_out(mat1), .out_valid(ov1), .drop_cnt(drop1));

  int   n_checks = 0, n_fail = 0;
  int   edge_n = 0;
  logic rst_seen = 1'b0;

  always @(posedge clk) begin
    edge_n   <= edge_n + 1;
    rst_seen <= rst;
  end

  // Scoreboard state
  logic [W-1:0] exp_q0[$], exp_q1[$];
  int           drop_q0[$], drop_q1[$], edge_q0[$], edge_q1[$];
  logic [W-1:0] cur_m[2];
  int           cur_d[2];

  // Reference model state: samples accepted since the last clear/reset
  int hist_i[$], hist_q[$];
  int fr_n[2];
  int pend_v = 0, pend_i = 0, pend_q = 0;

  function automatic int fl(input int d);
    return (d == 0) ? 4 : 8;
  endfunction

  function automatic int cw(input int d);
    return (d == 0) ? 8 : 2;
  endfunction

  function automatic logic [W-1:0] snap(input int d, output int drops);
    int cnt[81];
    logic [W-1:0] m;
    int n, mx, v, ii, qq;
    n = fl(d);
    mx = (1 << cw(d)) - 1;
    m = '0;
    drops = 0;
    for (int c = 0; c < 81; c++) cnt[c] = 0;
    for (int k = hist_i.size() - n; k < hist_i.size(); k++) begin
      ii = hist_i[k] + 8;
      qq = hist_q[k] + 8;
      if (ii >= 4 && ii <= 12 && qq >= 4 && qq <= 12) cnt[(qq - 4) * 9 + (ii - 4)]++;
      else drops++;
    end
    for (int c = 0; c < 81; c++) begin
      v = (cnt[c] > mx) ? mx : cnt[c];
      for (int b = 0; b < cw(d); b++) m[c * cw(d) + b] = v[b];
    end
    return m;
  endfunction

  task automatic commit(input int i, input int q);
    logic [W-1:0] m;
    int dr;
    hist_i.push_back(i);
    hist_q.push_back(q);
    for (int d = 0; d < 2; d++) begin
      fr_n[d]++;
      if (fr_n[d] == fl(d)) begin
        m = snap(d, dr);
`ifndef IQ_DENSITY_DROP_CNT_EN
        dr = 0;
`endif
        if (d == 0) begin
          exp_q0.push_back(m); drop_q0.push_back(dr); edge_q0.push_back(edge_n + 1);
        end else begin
          exp_q1.push_back(m); drop_q1.push_back(dr); edge_q1.push_back(edge_n + 1);
        end
        fr_n[d] = 0;
      end
    end
    while (hist_i.size() > 8) begin
      void'(hist_i.pop_front());
      void'(hist_q.pop_front());
    end
  endtask

  // A clear or reset discards both the sample issued with it and the one issued just before.
  task automatic model_step(input int v, input int i, input int q, input logic kill);
    if (kill) begin
      pend_v = 0;
      hist_i.delete();
      hist_q.delete();
      fr_n[0] = 0;
      fr_n[1] = 0;
    end else begin
      if (pend_v != 0) commit(pend_i, pend_q);
      pend_v = v;
      pend_i = i;
      pend_q = q;
    end
  endtask

  task automatic drive(input int v, input int i, input int q, input logic c, input logic r);
    in_valid = (v != 0);
    in_i     = 4'(i);
    in_q     = 4'(q);
    clear    = c;
    rst      = r;
    model_step(v, i, q, c | r);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input int d, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @edge %0d: got %h expected %h", nm, d, edge_n, act, exp);
    end
  endtask

  task automatic monitor(input int d, input logic ov, input logic [W-1:0] mat, input logic [15:0] drp);
    logic [W-1:0] em;
    int ed, eg, qs;
    if (rst_seen) begin
      cur_m[d] = '0;
      cur_d[d] = 0;
    end
    if (ov) begin
      qs = (d == 0) ? exp_q0.size() : exp_q1.size();
      if (qs == 0) begin
        chk("unexpected_out_valid", d, W'(1), W'(0));
      end else begin
        if (d == 0) begin
          em = exp_q0.pop_front(); ed = drop_q0.pop_front(); eg = edge_q0.pop_front();
        end else begin
          em = exp_q1.pop_front(); ed = drop_q1.pop_front(); eg = edge_q1.pop_front();
        end
        chk("snapshot", d, mat, em);
        chk("drop_cnt", d, W'(drp), W'(ed));
        chk("pulse_edge", d, W'(edge_n), W'(eg));
        cur_m[d] = em;
        cur_d[d] = ed;
      end
    end else begin
      chk("matrix_hold", d, mat, cur_m[d]);
      chk("drop_hold", d, W'(drp), W'(cur_d[d]));
    end
  endtask

  always @(negedge clk) begin
    monitor(0, ov0, W'(mat0), drop0);
    monitor(1, ov1, W'(mat1), drop1);
  end

  initial begin
    cur_m[0] = '0; cur_m[1] = '0;
    cur_d[0] = 0;  cur_d[1] = 0;
    fr_n[0] = 0;   fr_n[1] = 0;

    for (int k = 0; k < 3; k++) drive(0, 0, 0, 1'b0, 1'b1);
    idle(2);

    // Four centre samples, then a mixed in/out-of-range frame
    for (int k = 0; k < 4; k++) drive(1, 0, 0, 1'b0, 1'b0);
    idle(3);
    drive(1, -8, 0, 1'b0, 1'b0);
    drive(1, 7, 7, 1'b0, 1'b0);
    drive(1, 0, 0, 1'b0, 1'b0);
    drive(1, 1, -1, 1'b0, 1'b0);
    idle(3);

    // Eight back-to-back centre samples: two short frames, one saturating long frame
    for (int k = 0; k < 8; k++) drive(1, 0, 0, 1'b0, 1'b0);
    idle(3);

    // clear together with the fourth sample, then a fresh frame
    for (int k = 0; k < 3; k++) drive(1, k, -k, 1'b0, 1'b0);
    drive(1, 3, 3, 1'b1, 1'b0);
    drive(1, 1, 1, 1'b0, 1'b0);
    drive(1, 2, 2, 1'b0, 1'b0);
    drive(1, -1, 0, 1'b0, 1'b0);
    drive(1, 0, 0, 1'b0, 1'b0);
    idle(3);

    // Reset after three samples of a frame, then a new frame
    for (int k = 0; k < 3; k++) drive(1, -2, 2, 1'b0, 1'b0);
    drive(0, 0, 0, 1'b0, 1'b1);
    drive(0, 0, 0, 1'b0, 1'b1);
    drive(1, 3, -3, 1'b0, 1'b0);
    drive(1, -4, 4, 1'b0, 1'b0);
    drive(1, 0, 1, 1'b0, 1'b0);
    drive(1, 0, 1, 1'b0, 1'b0);
    idle(3);

    // Random traffic with bubbles and occasional clears
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 3) != 0) ? 1 : 0,
            int'($urandom_range(0, 15)) - 8,
            int'($urandom_range(0, 15)) - 8,
            ($urandom_range(0, 39) == 0), 1'b0);
    end
    // Long burst of centre-biased samples to exercise saturation in the 2-bit instance
    for (int k = 0; k < 64; k++)
      drive(1, int'($urandom_range(0, 2)) - 1, int'($urandom_range(0, 2)) - 1, 1'b0, 1'b0);
    idle(5);

    chk("leftover_expected", 0, W'(exp_q0.size()), W'(0));
    chk("leftover_expected", 1, W'(exp_q1.size()), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
